// File: rtl/sisc_ctrl_gen.sv
// sisc_ctrl_gen
// Control FSM for the SISC processor. Sequences each instruction through
// fetch, decode, execute, memory and writeback, and drives the datapath
// control strobes. Data memory accesses use a request/acknowledge
// handshake. Branches and NOOPs can optionally retire straight out of
// decode. HLT parks the controller in a halted state until reset.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset (START, counter cleared)
//   opcode     current IR opcode
//   mm         IR mm / branch condition mask
//   stat       status register flags
//   dm_ack     data memory completion, only looked at while dm_req=1
//   rf_we, pc_rst, pc_write, pc_sel, br_sel, rb_sel, ir_load, mm_sel,
//   dm_we      single-bit datapath strobes
//   alu_op     ALU function select (2'b10 when the ALU is unused)
//   wb_sel     register file writeback mux select
//   dm_req     data memory request
//   halted     high while in HALT
//   retire     one-cycle pulse per retired instruction
//   instr_cnt  retired-instruction count, wraps modulo 2^CNT_W
module sisc_ctrl_gen #(
    parameter int OP_W        = 4,
    parameter int MM_W        = 4,
    parameter int IMM_MM      = 8,
    parameter int CNT_W       = 16,
    parameter int FAST_BRANCH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic [MM_W-1:0]  mm,
    input  logic [MM_W-1:0]  stat,
    input  logic             dm_ack,
    output logic             rf_we,
    output logic             pc_rst,
    output logic             pc_write,
    output logic             pc_sel,
    output logic             br_sel,
    output logic             rb_sel,
    output logic             ir_load,
    output logic             mm_sel,
    output logic             dm_we,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             dm_req,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [OP_W-1:0] OP_NOOP = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LOD  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_STR  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SWP  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_BRA  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_BRR  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_BNR  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ALU  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_HLT  = OP_W'(15);

    state_t state;
    state_t next_state;

    logic is_nop, is_lod, is_str, is_swp;
    logic is_bra, is_brr, is_bne, is_bnr;
    logic is_alu, is_hlt;
    logic fast_retire;
    logic imm_mode;
    logic cond_set;
    logic [1:0] alu_sel;

    // Unassigned opcodes 9..14 are treated exactly like NOOP.
    assign is_nop = (opcode == OP_NOOP) ||
                    ((opcode >= OP_W'(9)) && (opcode <= OP_W'(14)));
    assign is_lod = (opcode == OP_LOD);
    assign is_str = (opcode == OP_STR);
    assign is_swp = (opcode == OP_SWP);
    assign is_bra = (opcode == OP_BRA);
    assign is_brr = (opcode == OP_BRR);
    assign is_bne = (opcode == OP_BNE);
    assign is_bnr = (opcode == OP_BNR);
    assign is_alu = (opcode == OP_ALU);
    assign is_hlt = (opcode == OP_HLT);

    // Instructions with no work after the PC update can leave from DECODE.
    assign fast_retire = (FAST_BRANCH != 0) &&
                         (is_nop || is_bra || is_brr || is_bne || is_bnr);

    assign imm_mode = (mm == MM_W'(IMM_MM));
    assign cond_set = |(mm & stat);
    assign alu_sel  = imm_mode ? 2'b01 : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_START;
            instr_cnt <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        rf_we      = 1'b0;
        pc_rst     = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        br_sel     = 1'b0;
        rb_sel     = 1'b0;
        ir_load    = 1'b0;
        mm_sel     = 1'b0;
        dm_we      = 1'b0;
        alu_op     = 2'b10;
        wb_sel     = 2'b00;
        dm_req     = 1'b0;
        halted     = 1'b0;
        retire     = 1'b0;

        case (state)
            S_START: begin
                pc_rst     = 1'b1;
                next_state = S_FETCH;
            end
            S_FETCH: begin
                ir_load    = 1'b1;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                pc_sel   = 1'b1;
                br_sel   = is_bra || is_bne;
                // Taken when any masked flag is set (BRA/BRR) or none is (BNE/BNR).
                pc_write = ((is_bra || is_brr) && cond_set) ||
                           ((is_bne || is_bnr) && !cond_set);
                if (is_hlt) begin
                    retire     = 1'b1;
                    next_state = S_HALT;
                end else if (fast_retire) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end else begin
                    next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_alu) begin
                    alu_op = alu_sel;
                end
                next_state = S_MEM;
            end
            S_MEM: begin
                next_state = S_WRITEBACK;
                if (is_alu) begin
                    alu_op = alu_sel;
                end else if (is_lod || is_str) begin
                    dm_req = 1'b1;
                    rb_sel = 1'b1;
                    mm_sel = imm_mode;
                    // Writes are gated by the ack so each access writes once.
                    if (dm_ack) begin
                        rf_we  = is_lod;
                        dm_we  = is_str;
                        wb_sel = is_lod ? 2'b01 : 2'b00;
                    end else begin
                        next_state = S_MEM;
                    end
                end else if (is_swp) begin
                    wb_sel = 2'b10;
                end
            end
            S_WRITEBACK: begin
                if (is_alu) begin
                    rf_we  = 1'b1;
                    alu_op = alu_sel;
                end else if (is_lod) begin
                    wb_sel = 2'b01;
                end else if (is_swp) begin
                    rf_we  = 1'b1;
                    wb_sel = 2'b11;
                end
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                next_state = S_START;
            end
        endcase
    end

endmodule

// File: tb/tb_sisc_ctrl_gen.sv
// tb_sisc_ctrl_gen
// Bench for sisc_ctrl_gen. Two instances share one input stream: one with
// the default 16-bit counter, one with a 2-bit counter to show wrapping.
// Each instruction is expanded into its expected cycle-by-cycle trace of
// control outputs; every cycle both instances are compared against it,
// and a few hand-computed counter values are pinned at chosen cycles.
module tb_sisc_ctrl_gen;

    typedef struct packed {
        logic       rf_we;
        logic       pc_rst;
        logic       pc_write;
        logic       pc_sel;
        logic       br_sel;
        logic       rb_sel;
        logic       ir_load;
        logic       mm_sel;
        logic       dm_we;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       dm_req;
        logic       halted;
        logic       retire;
    } ctl_t;

    typedef struct {
        logic       rst;
        logic [3:0] op;
        logic [3:0] mm;
        logic [3:0] stat;
        logic       ack;
        logic       chk;
        ctl_t       exp;
        int         pin16;
        int         pin2;
    } cyc_t;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [3:0] stat;
    logic       dm_ack;

    logic m_rf_we, m_pc_rst, m_pc_write, m_pc_sel, m_br_sel, m_rb_sel;
    logic m_ir_load, m_mm_sel, m_dm_we, m_dm_req, m_halted, m_retire;
    logic [1:0] m_alu_op, m_wb_sel;
    logic [15:0] m_instr_cnt;

    logic w_rf_we, w_pc_rst, w_pc_write, w_pc_sel, w_br_sel, w_rb_sel;
    logic w_ir_load, w_mm_sel, w_dm_we, w_dm_req, w_halted, w_retire;
    logic [1:0] w_alu_op, w_wb_sel;
    logic [1:0] w_instr_cnt;

    ctl_t m_act;
    ctl_t w_act;

    cyc_t prog[$];
    int   next_pin16 = -1;
    int   next_pin2  = -1;
    int   vectors    = 0;
    int   miscompares = 0;
    int   exp_cnt    = 0;
    int   cycle_no   = 0;

    sisc_ctrl_gen u_main (
        .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat),
        .dm_ack(dm_ack),
        .rf_we(m_rf_we), .pc_rst(m_pc_rst), .pc_write(m_pc_write),
        .pc_sel(m_pc_sel), .br_sel(m_br_sel), .rb_sel(m_rb_sel),
        .ir_load(m_ir_load), .mm_sel(m_mm_sel), .dm_we(m_dm_we),
        .alu_op(m_alu_op), .wb_sel(m_wb_sel), .dm_req(m_dm_req),
        .halted(m_halted), .retire(m_retire), .instr_cnt(m_instr_cnt)
    );

    sisc_ctrl_gen #(.CNT_W(2)) u_wrap (
        .clk(clk), .rst(rst), .opcode(opcode), .mm(mm), .stat(stat),
        .dm_ack(dm_ack),
        .rf_we(w_rf_we), .pc_rst(w_pc_rst), .pc_write(w_pc_write),
        .pc_sel(w_pc_sel), .br_sel(w_br_sel), .rb_sel(w_rb_sel),
        .ir_load(w_ir_load), .mm_sel(w_mm_sel), .dm_we(w_dm_we),
        .alu_op(w_alu_op), .wb_sel(w_wb_sel), .dm_req(w_dm_req),
        .halted(w_halted), .retire(w_retire), .instr_cnt(w_instr_cnt)
    );

    assign m_act = {m_rf_we, m_pc_rst, m_pc_write, m_pc_sel, m_br_sel, m_rb_sel,
                    m_ir_load, m_mm_sel, m_dm_we, m_alu_op, m_wb_sel,
                    m_dm_req, m_halted, m_retire};
    assign w_act = {w_rf_we, w_pc_rst, w_pc_write, w_pc_sel, w_br_sel, w_rb_sel,
                    w_ir_load, w_mm_sel, w_dm_we, w_alu_op, w_wb_sel,
                    w_dm_req, w_halted, w_retire};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic ctl_t idle();
        ctl_t c;
        c = '0;
        c.alu_op = 2'b10;
        return c;
    endfunction

    task automatic push(input logic r, input logic [3:0] op, input logic [3:0] m,
                        input logic [3:0] s, input logic ack, input logic chk,
                        input ctl_t exp);
        cyc_t e;
        e.rst = r; e.op = op; e.mm = m; e.stat = s; e.ack = ack;
        e.chk = chk; e.exp = exp;
        e.pin16 = next_pin16;
        e.pin2  = next_pin2;
        next_pin16 = -1;
        next_pin2  = -1;
        prog.push_back(e);
    endtask

    task automatic add_reset(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, idle());
    endtask

    task automatic add_start();
        ctl_t c;
        c = idle();
        c.pc_rst = 1'b1;
        push(1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, c);
    endtask

    task automatic add_halt(input int n);
        ctl_t c;
        c = idle();
        c.halted = 1'b1;
        for (int i = 0; i < n; i++) push(1'b0, 4'd15, 4'd0, 4'd0, 1'b1, 1'b1, c);
    endtask

    task automatic add_halt_reset();
        ctl_t c;
        c = idle();
        c.halted = 1'b1;
        push(1'b1, 4'd15, 4'd0, 4'd0, 1'b1, 1'b1, c);
    endtask

    // Expected trace of one instruction. waits = cycles with dm_ack low in a
    // memory access; abort >= 0 asserts rst after that many wait cycles.
    task automatic add_instr(input logic [3:0] op, input logic [3:0] m,
                             input logic [3:0] s, input int waits, input int abort);
        ctl_t c;
        logic hit;
        logic fast;
        logic [1:0] alu;
        hit  = ((m & s) != 4'd0);
        fast = (op == 4'd0) || (op >= 4'd4 && op <= 4'd7) || (op >= 4'd9 && op <= 4'd14);
        alu  = (m == 4'd8) ? 2'b01 : 2'b00;

        c = idle(); c.ir_load = 1'b1; c.pc_write = 1'b1;
        push(1'b0, op, m, s, 1'b1, 1'b1, c);

        c = idle(); c.pc_sel = 1'b1;
        c.br_sel   = (op == 4'd4) || (op == 4'd6);
        c.pc_write = ((op == 4'd4 || op == 4'd5) && hit) || ((op == 4'd6 || op == 4'd7) && !hit);
        c.retire   = (op == 4'd15) || fast;
        push(1'b0, op, m, s, 1'b1, 1'b1, c);
        if (op == 4'd15 || fast) return;

        c = idle();
        if (op == 4'd8) c.alu_op = alu;
        push(1'b0, op, m, s, 1'b1, 1'b1, c);

        if (op == 4'd1 || op == 4'd2) begin
            c = idle(); c.dm_req = 1'b1; c.rb_sel = 1'b1; c.mm_sel = (m == 4'd8);
            for (int i = 0; i < waits; i++) begin
                if (i == abort) begin
                    push(1'b1, op, m, s, 1'b0, 1'b1, c);
                    return;
                end
                push(1'b0, op, m, s, 1'b0, 1'b1, c);
            end
            if (op == 4'd1) begin c.rf_we = 1'b1; c.wb_sel = 2'b01; end
            else            c.dm_we = 1'b1;
            push(1'b0, op, m, s, 1'b1, 1'b1, c);
        end else begin
            c = idle();
            if (op == 4'd8) c.alu_op = alu;
            if (op == 4'd3) c.wb_sel = 2'b10;
            push(1'b0, op, m, s, 1'b1, 1'b1, c);
        end

        c = idle(); c.retire = 1'b1;
        if (op == 4'd8) begin c.rf_we = 1'b1; c.alu_op = alu; end
        if (op == 4'd1) c.wb_sel = 2'b01;
        if (op == 4'd3) begin c.rf_we = 1'b1; c.wb_sel = 2'b11; end
        push(1'b0, op, m, s, 1'b1, 1'b1, c);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cycle_no, act, exp);
        end
    endtask

    task automatic apply_stimulus(input cyc_t e);
        rst    = e.rst;
        opcode = e.op;
        mm     = e.mm;
        stat   = e.stat;
        dm_ack = e.ack;
    endtask

    task automatic check_output(input cyc_t e);
        if (e.chk) begin
            cmp("ctl_main", 32'(m_act), 32'(e.exp));
            cmp("ctl_wrap", 32'(w_act), 32'(e.exp));
            cmp("cnt_main", 32'(m_instr_cnt), 32'(exp_cnt % 65536));
            cmp("cnt_wrap", 32'(w_instr_cnt), 32'(exp_cnt % 4));
        end
        if (e.pin16 >= 0) cmp("pin_cnt_main", 32'(m_instr_cnt), 32'(e.pin16));
        if (e.pin2 >= 0)  cmp("pin_cnt_wrap", 32'(w_instr_cnt), 32'(e.pin2));
        if (e.rst)             exp_cnt = 0;
        else if (e.exp.retire) exp_cnt = exp_cnt + 1;
    endtask

    initial begin
        rst = 1'b1; opcode = '0; mm = '0; stat = '0; dm_ack = 1'b0;

        add_reset(2);
        next_pin16 = 0; next_pin2 = 0;
        add_start();
        add_instr(4'd8, 4'd8, 4'd0, 0, -1);
        next_pin16 = 1; next_pin2 = 1;
        add_instr(4'd8, 4'd3, 4'd5, 0, -1);
        add_instr(4'd1, 4'd8, 4'd0, 3, -1);
        add_instr(4'd2, 4'd2, 4'd0, 0, -1);
        add_instr(4'd3, 4'd0, 4'd0, 0, -1);
        add_instr(4'd4, 4'b0010, 4'b0010, 0, -1);
        add_instr(4'd4, 4'b0010, 4'b0000, 0, -1);
        add_instr(4'd7, 4'b0101, 4'b0000, 0, -1);
        add_instr(4'd6, 4'b0001, 4'b0001, 0, -1);
        add_instr(4'd5, 4'b0100, 4'b0100, 0, -1);
        add_instr(4'd11, 4'd0, 4'd0, 0, -1);
        next_pin16 = 11;
        add_instr(4'd1, 4'd8, 4'd0, 4, 2);
        next_pin16 = 0; next_pin2 = 0;
        add_start();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) next_pin2 = i % 4;
            if (i == 5) next_pin16 = 5;
            add_instr(4'd0, 4'd0, 4'd0, 0, -1);
        end
        add_instr(4'd15, 4'd0, 4'd0, 0, -1);
        next_pin16 = 7;
        add_halt(20);
        add_halt_reset();
        next_pin16 = 0;
        add_start();
        add_instr(4'd8, 4'd1, 4'd0, 0, -1);

        foreach (prog[i]) begin
            cycle_no = i;
            apply_stimulus(prog[i]);
            @(negedge clk);
            check_output(prog[i]);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sisc_ctrl_gen.md
Name: sisc_ctrl_gen

Overview:
- Parametrised next-generation SISC control FSM.
- Sequences fetch/decode/execute/mem/writeback and drives the datapath control strobes.
- New over the fixed-timing controller: ready/ack handshake with data memory, optional fast-branch path that skips execute/mem/writeback, a real HALT state with status output, and a retired-instruction counter.
- Sits between the IR/status register and the datapath (PC, register file, ALU, data memory).

Parameters:
OP_W, 4, opcode width
MM_W, 4, mm field and stat width
IMM_MM, 8, mm value selecting immediate addressing
CNT_W, 16, retired-instruction counter width
FAST_BRANCH, 1, 1 = NOOP/branch opcodes retire in DECODE; 0 = all opcodes take the full 5-state sequence

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
opcode  in  OP_W  current IR opcode (0 NOOP, 1 LOD, 2 STR, 3 SWP, 4 BRA, 5 BRR, 6 BNE, 7 BNR, 8 ALU, 15 HLT)
mm  in  MM_W  IR mm/condition field
stat  in  MM_W  status register
dm_ack  in  1  data memory completion, sampled only while dm_req=1
rf_we, pc_rst, pc_write, pc_sel, br_sel, rb_sel, ir_load, mm_sel, dm_we  out  1 each  datapath strobes
alu_op  out  2  ALU function select
wb_sel  out  2  writeback mux select
dm_req  out  1  data memory request
halted  out  1  high in HALT
retire  out  1  one-cycle pulse per retired instruction
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- States: START, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT. Registered state; outputs are combinational from state, opcode, mm, stat, dm_ack.
- Reset: rst sampled high at an edge forces START and clears instr_cnt to 0 from any state, including MEM with dm_req pending (request abandoned).
- Output defaults in every state: all 1-bit strobes 0, alu_op=2'b10, wb_sel=2'b00.
- START: pc_rst=1. Next state FETCH.
- FETCH: ir_load=1, pc_write=1. Next state DECODE.
- DECODE: pc_sel=1.
  - br_sel=1 for BRA/BNE, 0 otherwise.
  - pc_write=1 if (BRA|BRR) and (mm&stat)!=0, or if (BNE|BNR) and (mm&stat)==0.
  - HLT: next HALT, with a retire pulse.
  - FAST_BRANCH=1 and opcode in {0,4,5,6,7}: next FETCH, with a retire pulse.
  - Otherwise next EXECUTE.
- EXECUTE: opcode 8 gives alu_op = (mm==IMM_MM) ? 01 : 00. Next MEM.
- MEM:
  - Opcode 8: alu_op as in EXECUTE. Next WRITEBACK.
  - LOD/STR: dm_req=1, rb_sel=1, mm_sel=(mm==IMM_MM).
    - Stay in MEM while dm_ack=0.
    - In the cycle dm_ack=1: LOD gives rf_we=1 and wb_sel=01; STR gives dm_we=1. Next WRITEBACK.
    - rf_we/dm_we are never asserted without dm_ack, so exactly one write per access.
  - SWP: wb_sel=10. Next WRITEBACK.
  - Other opcodes: next WRITEBACK.
- WRITEBACK:
  - Opcode 8: rf_we=1, alu_op as in EXECUTE.
  - LOD: wb_sel=01, no write.
  - SWP: rf_we=1, wb_sel=11.
  - Next FETCH, with a retire pulse.
- HALT: halted=1, all strobes 0, no state change until rst.
- Opcodes 9–14 behave as NOOP.
- dm_ack while dm_req=0 is ignored.
- instr_cnt increments by 1 in the cycle after each retire pulse and wraps modulo 2^CNT_W.
- Latency: full instruction = 5 cycles + memory wait cycles. Fast branch/NOOP = 2 cycles.

Test Plan:
- Reset/boot: rst=1 for 2 cycles then 0 → START with pc_rst=1 and other strobes 0, alu_op=10; then FETCH with ir_load=pc_write=1; instr_cnt=0.
- ALU immediate: opcode=8, mm=8 → alu_op=01 in EXECUTE/MEM/WRITEBACK, rf_we=1 only in WRITEBACK, retire once, instr_cnt 0→1.
- LOD with wait: opcode=1, mm=8, dm_ack held low 3 cycles then high → dm_req=1 for 4 cycles, rf_we=1 and mm_sel=1 only in the ack cycle, then WRITEBACK.
- Branches, FAST_BRANCH=1: BRA mm=4'b0010, stat=4'b0010 → DECODE pc_write=1, br_sel=1, next FETCH. Same with stat=0 → pc_write=0. BNR with stat=0 → pc_write=1, br_sel=0. Each retires in 2 cycles.
- HLT: opcode=15 → DECODE→HALT, halted=1 held 20 cycles, instr_cnt incremented once; rst → START.
- Mid-access reset and counter wrap: rst in MEM with dm_req=1 → START next cycle, dm_req=0, instr_cnt=0. With CNT_W=2, 5 NOOPs → instr_cnt sequence 1,2,3,0,1.
